// File: rtl/pwd_out_arb.sv
// pwd_out_arb: round-robin arbiter that shares one registered password output
// channel among NUM_SRC password-compute engines.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   src_vld       - per-engine password valid
//   src_rdy       - per-engine accept (one-hot or zero)
//   src_password  - packed engine passwords, engine i at [i*DW +: DW]
//   out_vld       - output stage holds a password
//   out_rdy       - consumer accepts
//   password_o    - registered password
//   out_src_id    - engine index that produced password_o
//   out_cnt       - completed output handshakes, wrapping
module pwd_out_arb #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned OUTPUT_LEN = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 src_vld,
    output logic [NUM_SRC-1:0]                 src_rdy,
    input  logic [NUM_SRC*OUTPUT_LEN*8-1:0]    src_password,
    output logic                               out_vld,
    input  logic                               out_rdy,
    output logic [OUTPUT_LEN*8-1:0]            password_o,
    output logic [$clog2(NUM_SRC)-1:0]         out_src_id,
    output logic [CNT_W-1:0]                   out_cnt
);

    localparam int unsigned DW  = OUTPUT_LEN * 8;
    localparam int unsigned IDW = $clog2(NUM_SRC);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_any;
    logic           load_en;
    logic           src_xfer;
    logic           out_xfer;
    logic [DW-1:0]  sel_pw;

    // Search from rr_ptr upward (modulo NUM_SRC); first valid engine wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NUM_SRC);
            if (!grant_any && src_vld[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Password slice of the granted engine.
    always_comb begin
        sel_pw = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (grant_idx == IDW'(k)) begin
                sel_pw = src_password[k*DW +: DW];
            end
        end
    end

    assign load_en  = !out_vld || out_rdy;
    assign src_xfer = grant_any && load_en;
    assign out_xfer = out_vld && out_rdy;
    assign ptr_nxt  = (grant_idx == IDW'(NUM_SRC - 1)) ? '0 : grant_idx + IDW'(1);

    // Grant is masked while reset is held so no engine sees an accept.
    assign src_rdy = (src_xfer && rst_n) ? (NUM_SRC'(1) << grant_idx) : '0;

    // Output stage: a new word replaces a draining one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            password_o <= '0;
            out_src_id <= '0;
            rr_ptr     <= '0;
        end else if (src_xfer) begin
            out_vld    <= 1'b1;
            password_o <= sel_pw;
            out_src_id <= grant_idx;
            rr_ptr     <= ptr_nxt;
        end else if (out_xfer) begin
            out_vld    <= 1'b0;
        end
    end

    // Delivered-password counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (out_xfer) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pwd_out_arb.sv
// Testbench for pwd_out_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pwd_out_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned OL = 16;
    localparam int unsigned DW = OL * 8;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    src_vld = '0;
    logic [N-1:0]    src_rdy;
    logic [N*DW-1:0] src_password = '0;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [DW-1:0]   password_o;
    logic [IW-1:0]   out_src_id;
    logic [CW-1:0]   out_cnt;

    int checks = 0;
    int failures = 0;

    pwd_out_arb #(.NUM_SRC(N), .OUTPUT_LEN(OL), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_vld      (src_vld),
        .src_rdy      (src_rdy),
        .src_password (src_password),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .password_o   (password_o),
        .out_src_id   (out_src_id),
        .out_cnt      (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_vld;
    logic [DW-1:0] m_pw;
    int            m_id;
    int            m_cnt;
    int            m_ptr;
    int            m_g;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  acc_mask = '0;

    // Engine granted this cycle, or -1: scan ptr, ptr+1, ... modulo N.
    function automatic int pick(input int ptr, input logic [N-1:0] v, input bit ovld, input bit ordy);
        int i;
        if (ovld && !ordy) return -1;
        for (int k = 0; k < int'(N); k++) begin
            i = (ptr + k) % int'(N);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always_comb m_g = pick(m_ptr, src_vld, m_vld, out_rdy);
    always_comb exp_rdy = (m_g >= 0) ? (N'(1) << m_g) : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= 1'b0;
            m_pw  <= '0;
            m_id  <= 0;
            m_cnt <= 0;
            m_ptr <= 0;
        end else begin
            if (m_g >= 0) begin
                m_vld <= 1'b1;
                m_pw  <= src_password[m_g*DW +: DW];
                m_id  <= m_g;
                m_ptr <= (m_g + 1) % int'(N);
            end else if (m_vld && out_rdy) begin
                m_vld <= 1'b0;
            end
            if (m_vld && out_rdy) m_cnt <= (m_cnt + 1) % 16;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("src_rdy", DW'(src_rdy), DW'(exp_rdy));
            chk("out_vld", DW'(out_vld), DW'(m_vld));
            chk("password_o", password_o, m_pw);
            chk("out_src_id", DW'(out_src_id), DW'(m_id));
            chk("out_cnt", DW'(out_cnt), DW'(m_cnt));
            acc_mask <= exp_rdy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src_vld = '0;
        out_rdy = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_const();
        for (int i = 0; i < int'(N); i++)
            src_password[i*DW +: DW] = {4{8'hA0 + 8'(i), 24'h5A5A01}};
    endtask

    logic [DW-1:0] pw_const0;
    logic [DW-1:0] pw_single;

    initial begin
        pw_single = 128'h0123456789ABCDEF0123456789ABCDEF;
        pw_const0 = {4{8'hA0, 24'h5A5A01}};

        // Reset state, with all engines requesting during reset.
        #1 rst_n = 1'b0;
        src_vld = '1;
        #3;
        chk("rst_src_rdy", DW'(src_rdy), DW'(4'b0000));
        chk("rst_out_vld", DW'(out_vld), DW'(1'b0));
        chk("rst_password", password_o, '0);
        chk("rst_out_cnt", DW'(out_cnt), DW'(4'd0));
        step();
        do_reset();

        // Single engine.
        src_password[2*DW +: DW] = pw_single;
        src_vld = 4'b0100;
        out_rdy = 1'b1;
        #1 chk("single_rdy", DW'(src_rdy), DW'(4'b0100));
        step();
        src_vld = '0;
        #1;
        chk("single_vld", DW'(out_vld), DW'(1'b1));
        chk("single_pw", password_o, pw_single);
        chk("single_id", DW'(out_src_id), DW'(2'd2));
        step();
        #1;
        chk("single_cnt", DW'(out_cnt), DW'(4'd1));
        chk("single_rdy_drop", DW'(src_rdy), DW'(4'b0000));

        // All engines continuous.
        do_reset();
        load_const();
        src_vld = '1;
        out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_order", DW'(src_rdy), DW'(4'b0001 << (c % 4)));
            if (c > 0) chk("no_bubble", DW'(out_vld), DW'(1'b1));
            step();
        end
        src_vld = '0;
        #1 chk("cont_last_vld", DW'(out_vld), DW'(1'b1));
        step();
        #1;
        chk("cont_cnt8", DW'(out_cnt), DW'(4'd8));
        chk("cont_drained", DW'(out_vld), DW'(1'b0));

        // Backpressure.
        do_reset();
        load_const();
        src_vld = '1;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rdy", DW'(src_rdy), DW'(4'b0000));
            chk("bp_pw", password_o, pw_const0);
            chk("bp_id", DW'(out_src_id), DW'(2'd0));
            chk("bp_vld", DW'(out_vld), DW'(1'b1));
            step();
        end
        out_rdy = 1'b1;
        #1 chk("bp_release_rdy", DW'(src_rdy), DW'(4'b0010));
        step();

        // Sparse requesters.
        do_reset();
        src_vld = 4'b1010;
        out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("sparse_grant", DW'(src_rdy), DW'((c % 2) ? 4'b1000 : 4'b0010));
            step();
        end

        // Reset asserted mid-operation.
        do_reset();
        load_const();
        src_vld = 4'b0001;
        out_rdy = 1'b1;
        step();
        step();
        step();
        out_rdy = 1'b0;
        step();
        #1 chk("pre_rst_cnt", DW'(out_cnt), DW'(4'd2));
        #1 rst_n = 1'b0;
        #1;
        chk("async_vld", DW'(out_vld), DW'(1'b0));
        chk("async_pw", password_o, '0);
        chk("async_cnt", DW'(out_cnt), DW'(4'd0));
        src_vld = '1;
        step();
        rst_n = 1'b1;
        #1 chk("post_rst_grant", DW'(src_rdy), DW'(4'b0001));
        step();

        // Counter wrap (CW = 4).
        do_reset();
        src_vld = 4'b0001;
        out_rdy = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (e == 16) chk("wrap_15", DW'(out_cnt), DW'(4'd15));
            if (e == 17) chk("wrap_0", DW'(out_cnt), DW'(4'd0));
            if (e == 18) chk("wrap_1", DW'(out_cnt), DW'(4'd1));
        end

        // Randomized traffic honouring the hold-until-accepted rule.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!src_vld[i] || acc_mask[i]) begin
                    src_vld[i] = ($urandom % 3) != 0;
                    src_password[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            out_rdy = ($urandom % 4) != 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
